sine_sweep_controller: RTL and testbench

- Sequences the 32-bit phase step of the quarter-wave sine generator to produce frequency sweeps (chirps).
- Latches a sweep configuration on a start pulse and steps the phase step from a start value to a stop value in fixed increments, holding each value for a programmable dwell.
- Supports single-shot, sawtooth-repeat and triangle (up/down) modes.
- Sits between the control/register interface and the generator's phase-step and reset inputs.

---
 rtl/sine_sweep_controller.sv | 198 +++++++++++++++++++
 tb/tb_sine_sweep_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_sweep_controller.sv
// Frequency-sweep sequencer: steps the generator phase step from a start value to a stop value,
// holding each value for a programmable dwell, in single, sawtooth-repeat or triangle mode.
module sine_sweep_controller #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_hold,
    input  logic [PHASE_W-1:0] i_start_step,
    input  logic [PHASE_W-1:0] i_stop_step,
    input  logic [PHASE_W-1:0] i_step_inc,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [1:0]         i_mode,
    output logic [PHASE_W-1:0] o_phase_step,
    output logic               o_gen_rst,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_step_strobe,
    output logic               o_dir
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        M_SINGLE     = 2'd0,
        M_REPEAT     = 2'd1,
        M_TRIANGLE   = 2'd2,
        M_SINGLE_ALT = 2'd3
    } mode_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t               state_q, state_d;
    mode_t                mode_q, mode_d;
    logic [PHASE_W-1:0]   start_q, start_d;
    logic [PHASE_W-1:0]   stop_q, stop_d;
    logic [PHASE_W-1:0]   inc_q, inc_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 dir0_q, dir0_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [PHASE_W-1:0]   phase_step_q, phase_step_d;
    logic                 gen_rst_q, gen_rst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 step_strobe_q, step_strobe_d;
    logic                 dir_q, dir_d;

    logic [PHASE_W-1:0]   leg_target;
    logic [PHASE_W-1:0]   rev_target;
    logic                 at_target;

    // One step of size inc toward target; the extra carry/borrow bit catches wrap, which clamps too.
    function automatic logic [PHASE_W-1:0] step_toward(
        input logic [PHASE_W-1:0] cur,
        input logic [PHASE_W-1:0] inc,
        input logic               up,
        input logic [PHASE_W-1:0] target
    );
        logic [PHASE_W:0]   nxt;
        logic [PHASE_W-1:0] res;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, inc};
            res = (nxt[PHASE_W] || (nxt[PHASE_W-1:0] > target)) ? target : nxt[PHASE_W-1:0];
        end else begin
            nxt = {1'b0, cur} - {1'b0, inc};
            res = (nxt[PHASE_W] || (nxt[PHASE_W-1:0] < target)) ? target : nxt[PHASE_W-1:0];
        end
        return res;
    endfunction

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        start_d       = start_q;
        stop_d        = stop_q;
        inc_d         = inc_q;
        dwell_d       = dwell_q;
        dir0_d        = dir0_q;
        dwell_cnt_d   = dwell_cnt_q;
        phase_step_d  = phase_step_q;
        busy_d        = busy_q;
        dir_d         = dir_q;
        gen_rst_d     = 1'b0;
        done_d        = 1'b0;
        step_strobe_d = 1'b0;

        leg_target = (dir_q == dir0_q) ? stop_q : start_q;
        rev_target = (dir_q != dir0_q) ? stop_q : start_q;
        // A zero increment can never move, so it ends the leg like a reached target.
        at_target  = (phase_step_q == leg_target) || (inc_q == '0);

        if (i_abort) begin
            state_d      = S_IDLE;
            phase_step_d = '0;
            busy_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        start_d       = i_start_step;
                        stop_d        = i_stop_step;
                        inc_d         = i_step_inc;
                        dwell_d       = i_dwell;
                        mode_d        = mode_t'(i_mode);
                        dir0_d        = (i_stop_step >= i_start_step);
                        dir_d         = (i_stop_step >= i_start_step);
                        phase_step_d  = i_start_step;
                        dwell_cnt_d   = i_dwell;
                        gen_rst_d     = 1'b1;
                        step_strobe_d = 1'b1;
                        busy_d        = 1'b1;
                        state_d       = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!i_hold) begin
                        if (dwell_cnt_q != '0) begin
                            dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
                        end else if (!at_target) begin
                            phase_step_d  = step_toward(phase_step_q, inc_q, dir_q, leg_target);
                            step_strobe_d = 1'b1;
                            dwell_cnt_d   = dwell_q;
                        end else begin
                            case (mode_q)
                                M_REPEAT: begin
                                    phase_step_d  = start_q;
                                    step_strobe_d = 1'b1;
                                    dwell_cnt_d   = dwell_q;
                                end
                                M_TRIANGLE: begin
                                    // Turn around without repeating the endpoint.
                                    dir_d         = !dir_q;
                                    phase_step_d  = step_toward(phase_step_q, inc_q, !dir_q, rev_target);
                                    step_strobe_d = 1'b1;
                                    dwell_cnt_d   = dwell_q;
                                end
                                default: begin
                                    state_d = S_IDLE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            mode_q        <= M_SINGLE;
            start_q       <= '0;
            stop_q        <= '0;
            inc_q         <= '0;
            dwell_q       <= '0;
            dir0_q        <= 1'b0;
            dwell_cnt_q   <= '0;
            phase_step_q  <= '0;
            gen_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            step_strobe_q <= 1'b0;
            dir_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            inc_q         <= inc_d;
            dwell_q       <= dwell_d;
            dir0_q        <= dir0_d;
            dwell_cnt_q   <= dwell_cnt_d;
            phase_step_q  <= phase_step_d;
            gen_rst_q     <= gen_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            step_strobe_q <= step_strobe_d;
            dir_q         <= dir_d;
        end
    end

    assign o_phase_step  = phase_step_q;
    assign o_gen_rst     = gen_rst_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_step_strobe = step_strobe_q;
    assign o_dir         = dir_q;

endmodule

// File: tb/tb_sine_sweep_controller.sv
// Scoreboard bench for sine_sweep_controller: expected sweep values come from a leg-by-leg
// arithmetic model; a negedge monitor pops and compares on every strobe/done/gen_rst event.
module tb_sine_sweep_controller;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_hold = 1'b0;
    logic [31:0] i_start_step = '0;
    logic [31:0] i_stop_step = '0;
    logic [31:0] i_step_inc = '0;
    logic [15:0] i_dwell = '0;
    logic [1:0]  i_mode = '0;
    logic [31:0] o_phase_step;
    logic        o_gen_rst, o_busy, o_done, o_step_strobe, o_dir;

    sine_sweep_controller #(.PHASE_W(32), .DWELL_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_hold(i_hold),
        .i_start_step(i_start_step), .i_stop_step(i_stop_step), .i_step_inc(i_step_inc),
        .i_dwell(i_dwell), .i_mode(i_mode), .o_phase_step(o_phase_step), .o_gen_rst(o_gen_rst),
        .o_busy(o_busy), .o_done(o_done), .o_step_strobe(o_step_strobe), .o_dir(o_dir)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc++;

    typedef struct {
        logic [31:0] ph;
        logic        dir;
        logic        strobe;
        logic        done;
        logic        grst;
        logic        busy;
        int unsigned cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    exp_t mit;
    always @(negedge i_clk) begin
        if (o_step_strobe === 1'b1 || o_done === 1'b1 || o_gen_rst === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cycle %0d ph=%0h strobe=%b done=%b grst=%b, expected no event",
                         cyc, o_phase_step, o_step_strobe, o_done, o_gen_rst);
            end else begin
                mit = q.pop_front();
                if ({o_phase_step, o_dir, o_step_strobe, o_done, o_gen_rst, o_busy, cyc} !==
                    {mit.ph, mit.dir, mit.strobe, mit.done, mit.grst, mit.busy, mit.cyc}) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d ph=%0h dir=%b stb=%b done=%b grst=%b busy=%b, expected cyc=%0d ph=%0h dir=%b stb=%b done=%b grst=%b busy=%b",
                             cyc, o_phase_step, o_dir, o_step_strobe, o_done, o_gen_rst, o_busy,
                             mit.cyc, mit.ph, mit.dir, mit.strobe, mit.done, mit.grst, mit.busy);
                end
            end
        end
    end

    // Reference model: builds the sweep as a list of legs, then timestamps each value.
    task automatic push_seq(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                            input int unsigned d, input int mode, input int unsigned nmax,
                            input int unsigned m, input int unsigned hidx, input int unsigned hlen,
                            output int unsigned last, output logic ends_done, output logic [31:0] final_v);
        longint      vals[$];
        bit          dirs[$];
        bit          dir0, degen, single, ldir, incl;
        longint      a, b, cur, li;
        int unsigned leg, n;
        exp_t        it;
        dir0   = (e >= s);
        degen  = (inc == 0) || (s == e);
        single = (mode == 0) || (mode == 3);
        li     = longint'(inc);
        leg    = 0;
        while (vals.size() < nmax) begin
            ldir = (mode == 2 && (leg % 2) == 1) ? !dir0 : dir0;
            if (degen) begin
                vals.push_back(longint'(s));
                dirs.push_back(ldir);
            end else begin
                if (mode == 2 && leg > 0) begin
                    a = ((leg % 2) == 1) ? longint'(e) : longint'(s);
                    b = ((leg % 2) == 1) ? longint'(s) : longint'(e);
                    incl = 1'b0;
                end else begin
                    a = longint'(s);
                    b = longint'(e);
                    incl = 1'b1;
                end
                cur = a;
                if (incl) begin
                    vals.push_back(cur);
                    dirs.push_back(ldir);
                end
                while (cur != b) begin
                    cur = ldir ? cur + li : cur - li;
                    if (ldir ? (cur > b) : (cur < b)) cur = b;
                    vals.push_back(cur);
                    dirs.push_back(ldir);
                end
            end
            if (single) break;
            leg++;
        end
        ends_done = single && (vals.size() <= nmax);
        n = (vals.size() < nmax) ? vals.size() : nmax;
        for (int unsigned k = 0; k < n; k++) begin
            it.ph     = vals[k][31:0];
            it.dir    = dirs[k];
            it.strobe = 1'b1;
            it.done   = 1'b0;
            it.grst   = (k == 0);
            it.busy   = 1'b1;
            it.cyc    = m + 1 + k * (d + 1) + ((hlen > 0 && k > hidx) ? hlen : 0);
            q.push_back(it);
        end
        final_v = vals[n-1][31:0];
        last    = it.cyc;
        if (ends_done) begin
            it.strobe = 1'b0;
            it.done   = 1'b1;
            it.grst   = 1'b0;
            it.busy   = 1'b0;
            it.cyc    = m + 1 + n * (d + 1) + ((hlen > 0 && n > hidx) ? hlen : 0);
            q.push_back(it);
            last = it.cyc;
        end
    endtask

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                             input int unsigned d, input int mode, input int unsigned nmax,
                             input int unsigned hidx, input int unsigned hlen,
                             input bit inject, input bit use_rst);
        int unsigned m, last, c;
        logic        ends;
        logic [31:0] fv;
        m = cyc;
        push_seq(s, e, inc, d, mode, nmax, m, hidx, hlen, last, ends, fv);
        i_start_step = s; i_stop_step = e; i_step_inc = inc;
        i_dwell = d[15:0]; i_mode = mode[1:0]; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_start_step = $urandom; i_stop_step = $urandom; i_step_inc = $urandom;
        i_dwell = 16'($urandom); i_mode = 2'($urandom);
        if (hlen > 0) begin
            while (cyc < m + 1 + hidx * (d + 1)) @(negedge i_clk);
            i_hold = 1'b1;
            repeat (hlen) @(negedge i_clk);
            i_hold = 1'b0;
        end
        if (inject && last >= m + 4) begin
            c = $urandom_range(m + 1, last - 2);
            while (cyc < c) @(negedge i_clk);
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        while (cyc < last) @(negedge i_clk);
        if (ends) begin
            @(negedge i_clk);
            chk("drained_after_done", 64'(q.size()), 64'd0);
            chk("busy_after_done", 64'(o_busy), 64'd0);
            chk("final_value_held", 64'(o_phase_step), 64'(fv));
        end else begin
            if (use_rst) i_rst = 1'b1; else i_abort = 1'b1;
            @(negedge i_clk);
            i_rst = 1'b0;
            i_abort = 1'b0;
            chk("stop_phase_zero", 64'(o_phase_step), 64'd0);
            chk("stop_busy", 64'(o_busy), 64'd0);
            chk("stop_strobe", 64'(o_step_strobe), 64'd0);
            chk("drained_after_stop", 64'(q.size()), 64'd0);
            if (use_rst) begin
                chk("rst_dir", 64'(o_dir), 64'd0);
                chk("rst_gen_rst", 64'(o_gen_rst), 64'd0);
                chk("rst_done", 64'(o_done), 64'd0);
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before cycle 50000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, e, inc;
        longint      span, li;
        int unsigned sel;

        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        chk("reset_phase", 64'(o_phase_step), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_strobe", 64'(o_step_strobe), 64'd0);
        chk("reset_gen_rst", 64'(o_gen_rst), 64'd0);
        chk("reset_dir", 64'(o_dir), 64'd0);

        // Directed sweeps.
        run_sweep(32'd100, 32'd130, 32'd10, 2, 0, 100, 0, 0, 0, 0);
        run_sweep(32'd0, 32'd25, 32'd10, 0, 0, 100, 0, 0, 0, 0);
        run_sweep(32'd50, 32'd20, 32'd15, 0, 0, 100, 0, 0, 0, 0);
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 0, 100, 0, 0, 0, 0);
        run_sweep(32'd10, 32'd30, 32'd10, 0, 1, 9, 0, 0, 0, 0);
        run_sweep(32'd10, 32'd30, 32'd10, 0, 2, 11, 0, 0, 0, 0);
        run_sweep(32'd30, 32'd10, 32'd10, 1, 2, 9, 0, 0, 0, 0);
        run_sweep(32'd100, 32'd130, 32'd10, 2, 0, 100, 1, 5, 0, 0);
        run_sweep(32'd0, 32'd1000, 32'd1, 0, 0, 6, 0, 0, 0, 0);
        run_sweep(32'd77, 32'd500, 32'd0, 1, 3, 100, 0, 0, 0, 0);
        run_sweep(32'd42, 32'd42, 32'd5, 0, 2, 5, 0, 0, 0, 0);

        // Start and abort together in IDLE must leave the block idle.
        i_start_step = 32'd5; i_stop_step = 32'd9; i_step_inc = 32'd1; i_mode = 2'd0;
        i_start = 1'b1; i_abort = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; i_abort = 1'b0;
        chk("start_abort_busy", 64'(o_busy), 64'd0);
        @(negedge i_clk);
        chk("start_abort_still_idle", 64'(o_busy), 64'd0);

        // Reset mid-run, then a clean restart.
        run_sweep(32'd10, 32'd30, 32'd10, 0, 1, 5, 0, 0, 0, 1);
        run_sweep(32'd10, 32'd30, 32'd10, 0, 0, 100, 0, 0, 0, 0);

        // Randomized sweeps with ignored mid-run start pulses.
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            s = $urandom;
            e = $urandom;
            if (sel == 0) e = s;
            if (sel == 1) begin
                s = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                e = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            end
            if (sel == 2) begin
                s = 32'($urandom_range(0, 255));
                e = 32'($urandom_range(0, 255));
            end
            span = (e >= s) ? longint'(e) - longint'(s) : longint'(s) - longint'(e);
            li = span / longint'($urandom_range(1, 8)) + longint'($urandom_range(0, 3));
            if (sel == 3) li = 0;
            if (sel == 4) li = longint'($urandom | 32'h8000_0000);
            if (li > 64'h0000_0000_FFFF_FFFF) li = 64'h0000_0000_FFFF_FFFF;
            inc = li[31:0];
            run_sweep(s, e, inc, $urandom_range(0, 3), int'($urandom_range(0, 3)), 14, 0, 0, 1, 0);
        end

        repeat (2) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
